string_cmp_engine: RTL and testbench
====================================

Name: string_cmp_engine

Overview:
- Downstream consumer of the two Avalon-mapped string FIFOs (A and B) in the string HW accelerator.
- On a go pulse, pops 32-bit words (4 chars each) from both FIFOs in lockstep and compares them byte by byte, strcmp-style.
- Stops at the first mismatch, at a common NUL, or after len_words words.
- Publishes done, equal, ordering and first-difference index for the Avalon result/status register.

Parameters:
- MAX_WORDS, 4, FIFO depth in 32-bit words; upper bound for len_words.
- LEN_W, $clog2(MAX_WORDS+1), width of len_words.
- IDX_W, $clog2(4*MAX_WORDS)+1, width of the byte index (holds values 0..4*MAX_WORDS).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  single-cycle start pulse; honoured only in IDLE or DONE.
- clear  in  1  synchronous abort; returns to IDLE and clears results.
- len_words  in  LEN_W  words to compare; sampled on the accepted go.
- a_rdata  in  32  FIFO A head word (show-ahead); byte 0 = [31:24].
- a_empty  in  1  FIFO A empty.
- a_rd_en  out  1  pop FIFO A this cycle.
- b_rdata  in  32  FIFO B head word, same packing.
- b_empty  in  1  FIFO B empty.
- b_rd_en  out  1  pop FIFO B this cycle.
- busy  out  1  high in FETCH or CMP.
- done  out  1  level; high in DONE until the next accepted go or clear.
- equal  out  1  strings equal over the compared span.
- a_lt_b  out  1  first differing byte of A < B (unsigned); 0 when equal.
- diff_idx  out  IDX_W  byte index of first difference, NUL position, or 4*len_words.

Behaviour:
- Reset (reset low, async):
  - state = IDLE.
  - All outputs 0: a_rd_en = b_rd_en = 0; busy, done, equal, a_lt_b, diff_idx = 0.
  - Internal word counter and word registers cleared.
  - Reset mid-operation drops the compare; no further pops.
- States: IDLE, FETCH, CMP, DONE.
- IDLE / DONE:
  - go=1 latches len_words, zeroes the word counter, clears done/equal/a_lt_b/diff_idx.
  - If len_words=0: next state DONE with equal=1, diff_idx=0, and no pops.
  - Otherwise: next state FETCH.
  - len_words > MAX_WORDS is saturated to MAX_WORDS.
- FETCH:
  - When !a_empty && !b_empty: a_rd_en = b_rd_en = 1 for exactly one cycle; a_rdata/b_rdata registered; go to CMP.
  - If either FIFO is empty: no pop on either side; stall indefinitely.
  - Pops are always paired, so the FIFOs never desynchronise.
- CMP (one cycle per word):
  - Scan bytes 0..3 of the registered words, lowest index first.
  - First byte with a≠b: equal=0, a_lt_b=(a<b), diff_idx = 4*word + byte; go to DONE.
  - Otherwise, first byte with a==0: equal=1, diff_idx = NUL position; go to DONE.
  - Otherwise increment the word counter. If counter == len_words: equal=1, diff_idx = 4*len_words, go to DONE. Else go to FETCH.
- Throughput: 2 cycles per word once data is available. Latency from go to done is at least 2*N+1 cycles for N words.
- go while busy is ignored.
- clear has priority over go in every state: next state IDLE, results zeroed, no pop in that cycle.
- Words left in the FIFOs after early termination are not drained. Firmware flushes them through the FIFO status register.
- Result outputs are registered and change only on the CMP→DONE transition, or on go/clear/reset.

Optional Feature:
- STRCMP_NOCASE_EN
  - Defined: adds input port nocase (1 bit, sampled on go). When nocase=1, bytes 0x41–0x5A are folded to +0x20 before compare and ordering. diff_idx semantics are unchanged.
  - Undefined: the port is absent and comparison is exact binary.

Decomposition:
- Package string_hw_pkg contains:
  - state enum (IDLE, FETCH, CMP, DONE);
  - byte_t;
  - NUL = 8'h00;
  - BYTES_PER_WORD = 4;
  - function fold_case.
- Sub-module string_word_cmp: combinational 4-byte compare producing hit, hit_is_mismatch, hit_byte[1:0], a_lt_b. The engine holds the FSM, counters and result registers.

Test Plan:
- A="abcd","efg\0", B identical, len_words=2, FIFOs pre-filled, go → two pop pairs; done, equal=1, a_lt_b=0, diff_idx=7.
- A=0x61626364 (abcd), B=0x61626564 (abed), len_words=1 → equal=0, a_lt_b=1, diff_idx=2; exactly one pop pair.
- A=3 words, B filled one word at a time with 5-cycle gaps while A is full → no pops while b_empty; pops always paired; final equal=1, diff_idx=12.
- len_words=0, go → done in 1 cycle, equal=1, diff_idx=0, a_rd_en/b_rd_en never asserted.
- Reset low for 1 cycle during FETCH after one pop pair → all outputs 0 immediately; go after release restarts at word 0. Repeat the abort with clear in CMP → IDLE, no pop in that cycle.
- With STRCMP_NOCASE_EN: A="ABC\0", B="abc\0", nocase=1 → equal=1, diff_idx=3; nocase=0 → equal=0, a_lt_b=1, diff_idx=0.

Source files
------------

// File: rtl/string_hw_pkg.sv
// rtl/string_hw_pkg.sv - shared types, constants and helpers for the string compare engine
// Contents: FSM state enum, byte type, NUL, BYTES_PER_WORD, fold_case().
// No ports (package).
package string_hw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [7:0] byte_t;

    localparam byte_t NUL            = 8'h00;
    localparam int    BYTES_PER_WORD = 4;

    // Maps ASCII 'A'..'Z' onto 'a'..'z' when en is set; every other byte,
    // including NUL, passes through untouched.
    function automatic byte_t fold_case(input byte_t b, input logic en);
        if (en && (b >= 8'h41) && (b <= 8'h5A)) begin
            return b + 8'h20;
        end
        return b;
    endfunction

endpackage

// File: rtl/string_word_cmp.sv
// rtl/string_word_cmp.sv - combinational strcmp-style compare of one 4-byte word pair
// Ports:
//   a_word, b_word   in  32  words to compare; byte 0 = [31:24]
//   nocase           in  1   fold A-Z to a-z before comparing
//   hit              out 1   some byte differs or is a common NUL
//   hit_is_mismatch  out 1   the first hit byte differs (else it is a NUL)
//   hit_byte         out 2   index of the first hit byte
//   a_lt_b           out 1   at the first hit byte, A < B (unsigned)
module string_word_cmp
    import string_hw_pkg::*;
(
    input  logic [31:0] a_word,
    input  logic [31:0] b_word,
    input  logic        nocase,
    output logic        hit,
    output logic        hit_is_mismatch,
    output logic [1:0]  hit_byte,
    output logic        a_lt_b
);

    byte_t a_b [BYTES_PER_WORD];
    byte_t b_b [BYTES_PER_WORD];

    always_comb begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            a_b[i] = fold_case(a_word[31-8*i -: 8], nocase);
            b_b[i] = fold_case(b_word[31-8*i -: 8], nocase);
        end
    end

    // Scan from the highest byte down so the lowest-index hit is the one
    // that survives; this gives a priority encoder without an early exit.
    always_comb begin
        hit             = 1'b0;
        hit_is_mismatch = 1'b0;
        hit_byte        = 2'd0;
        a_lt_b          = 1'b0;
        for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
            if ((a_b[i] != b_b[i]) || (a_b[i] == NUL)) begin
                hit             = 1'b1;
                hit_is_mismatch = (a_b[i] != b_b[i]);
                hit_byte        = 2'(i);
                a_lt_b          = (a_b[i] < b_b[i]);
            end
        end
    end

endmodule

// File: rtl/string_cmp_engine.sv
// rtl/string_cmp_engine.sv - pops paired words from string FIFOs A/B and compares them strcmp-style
// Optional feature macro: STRCMP_NOCASE_EN (adds the nocase input, case-folded compare).
// Ports:
//   clk, reset        in   clock; asynchronous active-low reset
//   go, clear         in   start pulse (IDLE/DONE only); synchronous abort (priority)
//   len_words         in   LEN_W  words to compare, saturated to MAX_WORDS
//   nocase            in   1      (STRCMP_NOCASE_EN only) fold case, sampled on go
//   a_rdata, a_empty  in   FIFO A show-ahead head word and empty flag
//   a_rd_en           out  pop FIFO A
//   b_rdata, b_empty  in   FIFO B show-ahead head word and empty flag
//   b_rd_en           out  pop FIFO B
//   busy, done        out  FETCH/CMP active; result valid (level)
//   equal, a_lt_b     out  compare result
//   diff_idx          out  IDX_W  first difference / NUL position / 4*len_words
module string_cmp_engine
    import string_hw_pkg::*;
#(
    parameter int MAX_WORDS = 4,
    parameter int LEN_W     = $clog2(MAX_WORDS + 1),
    parameter int IDX_W     = $clog2(4 * MAX_WORDS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             clear,
    input  logic [LEN_W-1:0] len_words,
`ifdef STRCMP_NOCASE_EN
    input  logic             nocase,
`endif
    input  logic [31:0]      a_rdata,
    input  logic             a_empty,
    output logic             a_rd_en,
    input  logic [31:0]      b_rdata,
    input  logic             b_empty,
    output logic             b_rd_en,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             a_lt_b,
    output logic [IDX_W-1:0] diff_idx
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wa_q, wa_d;
    logic [31:0]      wb_q, wb_d;
    logic             done_q, done_d;
    logic             equal_q, equal_d;
    logic             lt_q, lt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             pop;
    logic             cmp_nocase;
    logic             hit, hit_mis, hit_lt;
    logic [1:0]       hit_byte;
    logic [LEN_W-1:0] len_sat;
    logic [LEN_W-1:0] cnt_inc;
    logic [IDX_W-1:0] word_base;

`ifdef STRCMP_NOCASE_EN
    logic nocase_q, nocase_d;
    assign cmp_nocase = nocase_q;
`else
    assign cmp_nocase = 1'b0;
`endif

    assign len_sat   = (len_words > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : len_words;
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign word_base = IDX_W'({cnt_q, 2'b00});

    string_word_cmp u_word_cmp (
        .a_word          (wa_q),
        .b_word          (wb_q),
        .nocase          (cmp_nocase),
        .hit             (hit),
        .hit_is_mismatch (hit_mis),
        .hit_byte        (hit_byte),
        .a_lt_b          (hit_lt)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wa_d     = wa_q;
        wb_d     = wb_q;
        done_d   = done_q;
        equal_d  = equal_q;
        lt_d     = lt_q;
        idx_d    = idx_q;
        pop      = 1'b0;
`ifdef STRCMP_NOCASE_EN
        nocase_d = nocase_q;
`endif
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            equal_d = 1'b0;
            lt_d    = 1'b0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        len_d   = len_sat;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        equal_d = 1'b0;
                        lt_d    = 1'b0;
                        idx_d   = '0;
`ifdef STRCMP_NOCASE_EN
                        nocase_d = nocase;
`endif
                        if (len_words == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            equal_d = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                FETCH: begin
                    // Both sides must have data so pops stay paired.
                    if (!a_empty && !b_empty) begin
                        pop     = 1'b1;
                        wa_d    = a_rdata;
                        wb_d    = b_rdata;
                        state_d = CMP;
                    end
                end
                CMP: begin
                    if (hit) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        equal_d = !hit_mis;
                        lt_d    = hit_mis && hit_lt;
                        idx_d   = word_base + IDX_W'(hit_byte);
                    end else if (cnt_inc == len_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        equal_d = 1'b1;
                        lt_d    = 1'b0;
                        idx_d   = IDX_W'({len_q, 2'b00});
                        cnt_d   = cnt_inc;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            wa_q     <= '0;
            wb_q     <= '0;
            done_q   <= 1'b0;
            equal_q  <= 1'b0;
            lt_q     <= 1'b0;
            idx_q    <= '0;
`ifdef STRCMP_NOCASE_EN
            nocase_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wa_q     <= wa_d;
            wb_q     <= wb_d;
            done_q   <= done_d;
            equal_q  <= equal_d;
            lt_q     <= lt_d;
            idx_q    <= idx_d;
`ifdef STRCMP_NOCASE_EN
            nocase_q <= nocase_d;
`endif
        end
    end

    assign a_rd_en  = pop;
    assign b_rd_en  = pop;
    assign busy     = (state_q == FETCH) || (state_q == CMP);
    assign done     = done_q;
    assign equal    = equal_q;
    assign a_lt_b   = lt_q;
    assign diff_idx = idx_q;

endmodule

// File: tb/tb_string_cmp_engine.sv
// tb/tb_string_cmp_engine.sv - scoreboard bench for string_cmp_engine with FIFO models
`timescale 1ns/1ps
module tb_string_cmp_engine;

    localparam int MAX_WORDS = 4;
    localparam int LEN_W     = $clog2(MAX_WORDS + 1);
    localparam int IDX_W     = $clog2(4 * MAX_WORDS) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             go = 1'b0;
    logic             clear = 1'b0;
    logic [LEN_W-1:0] len_words = '0;
`ifdef STRCMP_NOCASE_EN
    logic             nocase = 1'b0;
`endif
    logic [31:0]      a_rdata = '0;
    logic [31:0]      b_rdata = '0;
    logic             a_empty = 1'b1;
    logic             b_empty = 1'b1;
    logic             a_rd_en, b_rd_en, busy, done, equal, a_lt_b;
    logic [IDX_W-1:0] diff_idx;

    typedef struct {
        logic             eq;
        logic             lt;
        logic [IDX_W-1:0] idx;
        int               pops;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fa[$];
    logic [31:0] fb[$];
    logic [31:0] wa[4];
    logic [31:0] wb[4];
    bit          nc_sel = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int          pops_a = 0;
    int          pops_b = 0;

    always #5 clk = ~clk;

    string_cmp_engine #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .clear     (clear),
        .len_words (len_words),
`ifdef STRCMP_NOCASE_EN
        .nocase    (nocase),
`endif
        .a_rdata   (a_rdata),
        .a_empty   (a_empty),
        .a_rd_en   (a_rd_en),
        .b_rdata   (b_rdata),
        .b_empty   (b_empty),
        .b_rd_en   (b_rd_en),
        .busy      (busy),
        .done      (done),
        .equal     (equal),
        .a_lt_b    (a_lt_b),
        .diff_idx  (diff_idx)
    );

    task automatic refresh();
        a_empty = (fa.size() == 0);
        b_empty = (fb.size() == 0);
        a_rdata = a_empty ? 32'h0 : fa[0];
        b_rdata = b_empty ? 32'h0 : fb[0];
    endtask

    task automatic flush();
        fa.delete();
        fb.delete();
        refresh();
    endtask

    // Show-ahead FIFO models; pops land just after the edge that samples rd_en.
    always @(posedge clk) begin
        logic pa, pb;
        pa = a_rd_en;
        pb = b_rd_en;
        if (pa || pb) begin
            vectors++;
            if (pa !== pb) begin
                miscompares++;
                $display("FAIL pop_pairing: a_rd_en=%b b_rd_en=%b, required equal", pa, pb);
            end
            vectors++;
            if ((pa && fa.size() == 0) || (pb && fb.size() == 0)) begin
                miscompares++;
                $display("FAIL pop_on_empty: a_size=%0d b_size=%0d, required nonzero", fa.size(), fb.size());
            end
        end
        #1;
        if (pa && fa.size() > 0) begin void'(fa.pop_front()); pops_a++; end
        if (pb && fb.size() > 0) begin void'(fb.pop_front()); pops_b++; end
        refresh();
    end

    function automatic exp_t model(input int len);
        exp_t        e;
        int          n;
        logic [7:0]  ca, cb;
        n      = (len > MAX_WORDS) ? MAX_WORDS : len;
        e.eq   = 1'b1;
        e.lt   = 1'b0;
        e.idx  = IDX_W'(4 * n);
        e.pops = n;
        for (int i = 0; i < 4 * n; i++) begin
            ca = 8'(wa[i/4] >> (8 * (3 - i % 4)));
            cb = 8'(wb[i/4] >> (8 * (3 - i % 4)));
            if (nc_sel && ca >= 8'h41 && ca <= 8'h5A) ca = ca + 8'h20;
            if (nc_sel && cb >= 8'h41 && cb <= 8'h5A) cb = cb + 8'h20;
            if (ca != cb) begin
                e.eq = 1'b0; e.lt = (ca < cb); e.idx = IDX_W'(i); e.pops = i / 4 + 1;
                return e;
            end
            if (ca == 8'h00) begin
                e.idx = IDX_W'(i); e.pops = i / 4 + 1;
                return e;
            end
        end
        return e;
    endfunction

    task automatic load(input int n_a, input int n_b, input int len);
        for (int i = 0; i < n_a; i++) fa.push_back(wa[i]);
        for (int i = 0; i < n_b; i++) fb.push_back(wb[i]);
        refresh();
        sb.push_back(model(len));
    endtask

    task automatic pulse_go(input int len);
        @(negedge clk);
        go        = 1'b1;
        len_words = LEN_W'(len);
`ifdef STRCMP_NOCASE_EN
        nocase    = nc_sel;
`endif
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic run_cmp(input int len, input string name, output int cyc);
        exp_t e;
        pops_a = 0;
        pops_b = 0;
        pulse_go(len);
        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL %s_done: got %b after %0d cycles, required 1", name, done, cyc); end
        vectors++;
        if (equal !== e.eq) begin miscompares++; $display("FAIL %s_equal: got %b required %b", name, equal, e.eq); end
        vectors++;
        if (a_lt_b !== e.lt) begin miscompares++; $display("FAIL %s_a_lt_b: got %b required %b", name, a_lt_b, e.lt); end
        vectors++;
        if (diff_idx !== e.idx) begin miscompares++; $display("FAIL %s_diff_idx: got %0d required %0d", name, diff_idx, e.idx); end
        vectors++;
        if (pops_a !== e.pops || pops_b !== e.pops) begin
            miscompares++;
            $display("FAIL %s_pops: got a=%0d b=%0d required %0d", name, pops_a, pops_b, e.pops);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy: got %b required 0", name, busy); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({a_rd_en, b_rd_en, busy, done, equal, a_lt_b, diff_idx} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 0", {a_rd_en, b_rd_en, busy, done, equal, a_lt_b, diff_idx});
        end
        reset = 1'b1;
    endtask

    task automatic test_equal_nul();
        int cyc;
        flush();
        wa = '{32'h61626364, 32'h65666700, 32'h0, 32'h0};
        wb = wa;
        load(2, 2, 2);
        run_cmp(2, "equal_nul", cyc);
        vectors++;
        if (cyc != 4) begin miscompares++; $display("FAIL equal_nul_latency: got %0d required 4", cyc); end
    endtask

    task automatic test_mismatch();
        int cyc;
        flush();
        wa = '{32'h61626364, 32'h0, 32'h0, 32'h0};
        wb = '{32'h61626564, 32'h0, 32'h0, 32'h0};
        load(1, 1, 1);
        run_cmp(1, "mismatch_lt", cyc);
        vectors++;
        if (cyc != 2) begin miscompares++; $display("FAIL mismatch_latency: got %0d required 2", cyc); end
        // A greater than B in the second word, back-to-back from DONE.
        flush();
        wa = '{32'h61626364, 32'h7A797800, 32'h0, 32'h0};
        wb = '{32'h61626364, 32'h61626300, 32'h0, 32'h0};
        load(2, 2, 3);
        run_cmp(3, "mismatch_gt", cyc);
        // A ends early: its NUL against a live B byte is a difference.
        flush();
        wa = '{32'h61620000, 32'h0, 32'h0, 32'h0};
        wb = '{32'h61626300, 32'h0, 32'h0, 32'h0};
        load(1, 1, 1);
        run_cmp(1, "nul_vs_char", cyc);
    endtask

    task automatic test_len_zero();
        int cyc;
        flush();
        wa = '{32'h61626364, 32'h0, 32'h0, 32'h0};
        wb = wa;
        load(1, 1, 0);
        run_cmp(0, "len_zero", cyc);
        vectors++;
        if (cyc != 0) begin miscompares++; $display("FAIL len_zero_latency: got %0d required 0", cyc); end
    endtask

    task automatic test_saturate();
        int cyc;
        flush();
        wa = '{32'h31323334, 32'h35363738, 32'h41424344, 32'h45464748};
        wb = wa;
        load(4, 4, 7);
        run_cmp(7, "saturate", cyc);
    endtask

    task automatic test_gap();
        int cyc;
        flush();
        wa = '{32'h6A6B6C6D, 32'h6E6F7071, 32'h72737475, 32'h0};
        wb = wa;
        load(3, 0, 3);
        fork
            run_cmp(3, "gap", cyc);
            begin
                for (int i = 0; i < 3; i++) begin
                    repeat (5) @(negedge clk);
                    fb.push_back(wb[i]);
                    refresh();
                end
            end
        join
    endtask

    task automatic test_reset_abort();
        int cyc;
        flush();
        wa = '{32'h61626364, 32'h65666768, 32'h0, 32'h0};
        wb = wa;
        for (int i = 0; i < 2; i++) fa.push_back(wa[i]);
        fb.push_back(wb[0]);
        refresh();
        pops_a = 0;
        pops_b = 0;
        pulse_go(2);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (pops_a != 1 || pops_b != 1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: got pops a=%0d b=%0d busy=%b required 1 1 1", pops_a, pops_b, busy);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({a_rd_en, b_rd_en, busy, done, equal, a_lt_b, diff_idx} !== '0) begin
            miscompares++;
            $display("FAIL abort_reset_outputs: got %b required 0", {a_rd_en, b_rd_en, busy, done, equal, a_lt_b, diff_idx});
        end
        @(negedge clk);
        reset = 1'b1;
        flush();
        wa = '{32'h61626364, 32'h65666768, 32'h0, 32'h0};
        wb = '{32'h61626364, 32'h65666868, 32'h0, 32'h0};
        load(2, 2, 2);
        run_cmp(2, "after_reset", cyc);
    endtask

    task automatic test_clear();
        // Clear from DONE zeroes the published result.
        vectors++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        if ({done, equal, a_lt_b, diff_idx} !== '0) begin
            miscompares++;
            $display("FAIL clear_done: got %b required 0", {done, equal, a_lt_b, diff_idx});
        end
        flush();
        wa = '{32'h61626364, 32'h65666768, 32'h0, 32'h0};
        wb = wa;
        for (int i = 0; i < 2; i++) begin fa.push_back(wa[i]); fb.push_back(wb[i]); end
        refresh();
        pops_a = 0;
        pops_b = 0;
        // Clear wins over go.
        go    = 1'b1;
        clear = 1'b1;
        len_words = LEN_W'(2);
        @(negedge clk);
        go    = 1'b0;
        clear = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_over_go: busy got %b required 0", busy); end
        // Clear in FETCH with data available suppresses the pop.
        pulse_go(2);
        clear = 1'b1;
        #1;
        vectors++;
        if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_fetch_pop: got a=%b b=%b required 0 0", a_rd_en, b_rd_en);
        end
        @(negedge clk);
        clear = 1'b0;
        // Clear in CMP after one pop pair.
        pulse_go(2);
        @(negedge clk);
        clear = 1'b1;
        #1;
        vectors++;
        if (a_rd_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_cmp_state: got rd_en=%b busy=%b required 0 1", a_rd_en, busy);
        end
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || pops_a != 1 || pops_b != 1) begin
            miscompares++;
            $display("FAIL clear_cmp_idle: got busy=%b done=%b pops a=%0d b=%0d required 0 0 1 1", busy, done, pops_a, pops_b);
        end
    endtask

`ifdef STRCMP_NOCASE_EN
    task automatic test_nocase();
        int cyc;
        flush();
        wa = '{32'h41424300, 32'h0, 32'h0, 32'h0};
        wb = '{32'h61626300, 32'h0, 32'h0, 32'h0};
        nc_sel = 1'b1;
        load(1, 1, 1);
        run_cmp(1, "nocase_on", cyc);
        flush();
        nc_sel = 1'b0;
        load(1, 1, 1);
        run_cmp(1, "nocase_off", cyc);
    endtask
`endif

    initial begin
        test_reset();
        test_equal_nul();
        test_mismatch();
        test_len_zero();
        test_saturate();
        test_gap();
        test_reset_abort();
        test_clear();
`ifdef STRCMP_NOCASE_EN
        test_nocase();
`endif
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left required 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
